// File: rtl/uart_rx.sv
// 8N1 serial receiver, LSB first. It recovers one byte per frame from an asynchronous line.
// Each frame ends in a one-cycle valid strobe or a one-cycle framing-error strobe.
module uart_rx #(
    parameter int unsigned clk_hz    = 50_000_000,
    parameter int unsigned baud_rate = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned CPB     = clk_hz / baud_rate;
    localparam int unsigned HALF    = CPB / 2;
    localparam logic [15:0] CPB_M1  = 16'(CPB - 1);
    localparam logic [15:0] HALF_M1 = 16'(HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t      state_q;
    logic        s1_q, s2_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  sh_q;
    logic [7:0]  rx_data_q;
    logic        rx_valid_q, frame_err_q, rx_busy_q;

    logic        rx_s;
    logic [15:0] cnt_d;
    logic [7:0]  sh_d;

    assign rx_s  = s2_q;
    assign cnt_d = cnt_q + 16'd1;
    assign sh_d  = {rx_s, sh_q[7:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            s1_q        <= 1'b1;
            s2_q        <= 1'b1;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            sh_q        <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rx_busy_q   <= 1'b0;
        end else begin
            s1_q        <= rx;
            s2_q        <= s1_q;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_q   <= S_START;
                        cnt_q     <= '0;
                        rx_busy_q <= 1'b1;
                    end
                end
                S_START: begin
                    cnt_q <= cnt_d;
                    // Re-check the line at mid start bit; a high line here was only a glitch.
                    if (cnt_q == HALF_M1) begin
                        if (!rx_s) begin
                            state_q   <= S_DATA;
                            cnt_q     <= '0;
                            bit_idx_q <= '0;
                        end else begin
                            state_q   <= S_IDLE;
                            rx_busy_q <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == CPB_M1) begin
                        sh_q  <= sh_d;
                        cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == CPB_M1) begin
                        rx_data_q <= sh_q;
                        cnt_q     <= '0;
                        if (rx_s) begin
                            rx_valid_q <= 1'b1;
                            state_q    <= S_IDLE;
                            rx_busy_q  <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    // A held-low line is a break, not a new start bit; wait for idle.
                    if (rx_s) begin
                        state_q   <= S_IDLE;
                        rx_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    rx_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CPB=16 / HALF=8.
// A negedge monitor logs strobes, and the main sequence checks the log with immediate assertions.
module tb_uart_rx;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int         v_cyc[$];
    logic [7:0] v_dat[$];
    int         e_cyc[$];
    logic [7:0] e_dat[$];
    int         both_n = 0;
    int         long_n = 0;
    logic       pv = 1'b0;
    logic       pe = 1'b0;

    always #5 clk = ~clk;

    uart_rx #(
        .clk_hz   (16),
        .baud_rate(1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rx_valid) begin
            v_cyc.push_back(cyc);
            v_dat.push_back(rx_data);
            $display("strobe valid cyc=%0d data=%02h", cyc, rx_data);
        end
        if (frame_err) begin
            e_cyc.push_back(cyc);
            e_dat.push_back(rx_data);
            $display("strobe frame_err cyc=%0d data=%02h", cyc, rx_data);
        end
        if (rx_valid && frame_err) both_n++;
        if ((rx_valid && pv) || (frame_err && pe)) long_n++;
        pv = rx_valid;
        pe = frame_err;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Starts at a negedge; s is the cycle count just before edge 1.
    task automatic send_frame(input logic [7:0] d, input logic stop, output int s);
        s  = cyc;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (16) @(negedge clk);
        end
        rx = stop;
        repeat (16) @(negedge clk);
        $display("sent frame %02h stop=%0b start_cyc=%0d", d, stop, s);
    endtask

    initial begin
        int s, s2, n0, e0, busy_n, first_busy;
        logic [7:0] d77;

        // Reset with the line idle.
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        chk("in_reset_outputs", {20'd0, rx_data, rx_valid, frame_err, rx_busy, 1'b0}, 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            chk("post_reset_outputs", {21'd0, rx_data, rx_valid, frame_err, rx_busy}, 32'd0);
        end

        // Good frame 0xA5.
        n0 = v_cyc.size();
        e0 = e_cyc.size();
        send_frame(8'hA5, 1'b1, s);
        idle(20);
        chk("a5_valid_count", v_cyc.size() - n0, 1);
        chk("a5_err_count", e_cyc.size() - e0, 0);
        chk("a5_latency", v_cyc[n0] - s, 155);
        chk("a5_data", {24'd0, v_dat[n0]}, 32'hA5);
        chk("a5_busy_idle", {31'd0, rx_busy}, 0);

        // Short low glitch: a false start.
        n0 = v_cyc.size();
        e0 = e_cyc.size();
        busy_n = 0;
        first_busy = -1;
        rx = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 4) rx = 1'b1;
            if (rx_busy) begin
                busy_n++;
                if (first_busy < 0) first_busy = k;
            end
        end
        $display("glitch busy_cycles=%0d first=%0d", busy_n, first_busy);
        chk("glitch_busy_cycles", busy_n, 8);
        chk("glitch_busy_first", first_busy, 3);
        chk("glitch_no_valid", v_cyc.size() - n0, 0);
        chk("glitch_no_err", e_cyc.size() - e0, 0);

        // Frame 0x3C with stop bit low, then a 40-cycle break.
        n0 = v_cyc.size();
        e0 = e_cyc.size();
        send_frame(8'h3C, 1'b0, s);
        busy_n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rx_busy) busy_n++;
        end
        chk("brk_err_count", e_cyc.size() - e0, 1);
        chk("brk_no_valid", v_cyc.size() - n0, 0);
        chk("brk_err_latency", e_cyc[e0] - s, 155);
        chk("brk_err_data", {24'd0, e_dat[e0]}, 32'h3C);
        chk("brk_rx_data_hold", {24'd0, rx_data}, 32'h3C);
        chk("brk_busy_held", busy_n, 40);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        chk("brk_busy_before_exit", {31'd0, rx_busy}, 1);
        @(negedge clk);
        chk("brk_busy_after_exit", {31'd0, rx_busy}, 0);
        idle(10);
        n0 = v_cyc.size();
        send_frame(8'h81, 1'b1, s);
        idle(20);
        chk("x81_valid_count", v_cyc.size() - n0, 1);
        chk("x81_data", {24'd0, v_dat[n0]}, 32'h81);
        chk("x81_latency", v_cyc[n0] - s, 155);

        // Back-to-back 0x00 then 0xFF.
        n0 = v_cyc.size();
        e0 = e_cyc.size();
        send_frame(8'h00, 1'b1, s);
        send_frame(8'hFF, 1'b1, s2);
        idle(20);
        chk("b2b_valid_count", v_cyc.size() - n0, 2);
        chk("b2b_no_err", e_cyc.size() - e0, 0);
        chk("b2b_first_data", {24'd0, v_dat[n0]}, 32'h00);
        chk("b2b_second_data", {24'd0, v_dat[n0+1]}, 32'hFF);
        chk("b2b_spacing", v_cyc[n0+1] - v_cyc[n0], 160);
        chk("b2b_first_latency", v_cyc[n0] - s, 155);

        // Reset pulse in the middle of data bit 4 of 0x77.
        n0 = v_cyc.size();
        e0 = e_cyc.size();
        d77 = 8'h77;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = d77[i];
            repeat (16) @(negedge clk);
        end
        rx = d77[4];
        repeat (8) @(negedge clk);
        chk("mid_busy_before_reset", {31'd0, rx_busy}, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_clear", {21'd0, rx_data, rx_valid, frame_err, rx_busy}, 32'd0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(200);
        chk("mid_no_valid", v_cyc.size() - n0, 0);
        chk("mid_no_err", e_cyc.size() - e0, 0);
        send_frame(8'h5A, 1'b1, s);
        idle(20);
        chk("x5a_valid_count", v_cyc.size() - n0, 1);
        chk("x5a_data", {24'd0, v_dat[n0]}, 32'h5A);
        chk("x5a_latency", v_cyc[n0] - s, 155);

        chk("strobe_overlap", both_n, 0);
        chk("strobe_width", long_n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
